// File: rtl/plasticine_mem_req_ctrl.sv
// Request controller between the Plasticine address generators and DRAMSim2:
// one shared request FIFO, bounded in-flight tracking and a drain/done handshake.
module plasticine_mem_req_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_enq_val,
    output logic              io_enq_rdy,
    input  logic              io_enq_is_wr,
    input  logic [ADDR_W-1:0] io_enq_addr,
    output logic              io_tx_enq,
    input  logic              io_tx_rdy,
    output logic              io_tx_is_wr,
    output logic [ADDR_W-1:0] io_tx_addr,
    input  logic              io_tx_comp,
    input  logic              io_drain,
    output logic              io_done,
    output logic              io_idle,
    output logic [CNT_W-1:0]  io_outstanding,
    output logic [CNT_W-1:0]  io_comp_cnt,
    output logic              io_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DEPTH-1:0]  wr_mem;
    logic [PTR_W-1:0]  enq_ptr, deq_ptr, enq_ptr_nxt;
    logic              full, empty;
    logic [1:0]        state;
    logic [CNT_W-1:0]  outstanding, comp_cnt;
    logic              err;
    logic              push, accept, spurious;

    assign enq_ptr_nxt = enq_ptr + PTR_W'(1);
    assign empty       = !full && (enq_ptr == deq_ptr);
    assign io_enq_rdy  = !full && (state == RUN);
    assign push        = io_enq_val && io_enq_rdy;
    assign io_tx_enq   = !empty && (outstanding < MAX_OUT_C) && (state != DONE);
    assign accept      = io_tx_enq && io_tx_rdy;
    // A completion with nothing in flight (and no accept this cycle) is a protocol error.
    assign spurious    = io_tx_comp && !accept && (outstanding == '0);

    assign io_tx_addr     = addr_mem[deq_ptr];
    assign io_tx_is_wr    = wr_mem[deq_ptr];
    assign io_done        = (state == DONE);
    assign io_idle        = empty && (outstanding == '0);
    assign io_outstanding = outstanding;
    assign io_comp_cnt    = comp_cnt;
    assign io_err         = err;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[enq_ptr] <= io_enq_addr;
            wr_mem[enq_ptr]   <= io_enq_is_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            full    <= 1'b0;
        end else begin
            if (push) enq_ptr <= enq_ptr_nxt;
            if (accept) deq_ptr <= deq_ptr + PTR_W'(1);
            if (accept && !push) begin
                full <= 1'b0;
            end else if (push && !accept && (enq_ptr_nxt == deq_ptr)) begin
                full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            comp_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            if (accept && !io_tx_comp) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (io_tx_comp && !accept && (outstanding != '0)) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (io_tx_comp && !spurious) comp_cnt <= comp_cnt + CNT_W'(1);
            if (spurious) err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (io_drain) state <= DRAIN;
                DRAIN:   if (empty && (outstanding == '0) && !accept && !io_tx_comp) begin
                    state <= DONE;
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_plasticine_mem_req_ctrl.sv
// Scoreboard bench for plasticine_mem_req_ctrl: issue order, outstanding limit,
// drain/done, spurious completion, counter wrap and asynchronous reset.
module tb_plasticine_mem_req_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned CNT_W   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_enq_val, io_enq_rdy, io_enq_is_wr;
    logic [ADDR_W-1:0] io_enq_addr;
    logic              io_tx_enq, io_tx_rdy, io_tx_is_wr;
    logic [ADDR_W-1:0] io_tx_addr;
    logic              io_tx_comp, io_drain, io_done, io_idle, io_err;
    logic [CNT_W-1:0]  io_outstanding, io_comp_cnt;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    logic [ADDR_W:0] sb [$];

    plasticine_mem_req_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .MAX_OUT(MAX_OUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_enq_val    (io_enq_val),
        .io_enq_rdy    (io_enq_rdy),
        .io_enq_is_wr  (io_enq_is_wr),
        .io_enq_addr   (io_enq_addr),
        .io_tx_enq     (io_tx_enq),
        .io_tx_rdy     (io_tx_rdy),
        .io_tx_is_wr   (io_tx_is_wr),
        .io_tx_addr    (io_tx_addr),
        .io_tx_comp    (io_tx_comp),
        .io_drain      (io_drain),
        .io_done       (io_done),
        .io_idle       (io_idle),
        .io_outstanding(io_outstanding),
        .io_comp_cnt   (io_comp_cnt),
        .io_err        (io_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_wr, input logic [ADDR_W-1:0] addr);
        io_enq_val   = 1'b1;
        io_enq_is_wr = is_wr;
        io_enq_addr  = addr;
        step();
        io_enq_val = 1'b0;
    endtask

    // Negedge monitor: record accepted requests, compare every issued transaction.
    always @(negedge clk) begin
        if (reset) begin
            if (io_enq_val && io_enq_rdy) sb.push_back({io_enq_is_wr, io_enq_addr});
            if (io_tx_enq && io_tx_rdy) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    check("tx_unexpected", 64'(io_tx_addr), 64'hffff_ffff_ffff_ffff);
                end else begin
                    check("tx_order", 64'({io_tx_is_wr, io_tx_addr}), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int a0;
        int idle_cyc;
        int done_cyc;
        int done_n;
        logic [CNT_W-1:0] exp_cnt;

        reset = 1'b0;
        io_enq_val = 1'b0; io_enq_is_wr = 1'b0; io_enq_addr = '0;
        io_tx_rdy = 1'b0; io_tx_comp = 1'b0; io_drain = 1'b0;
        #1;
        check("rst_enq_rdy", 64'(io_enq_rdy), 64'd1);
        check("rst_tx_enq", 64'(io_tx_enq), 64'd0);
        check("rst_idle", 64'(io_idle), 64'd1);
        check("rst_done", 64'(io_done), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();

        // Fill under backpressure, refuse a 5th, then issue in order.
        for (int i = 0; i < 4; i++) push(i[0], ADDR_W'(32'h10 + i));
        check("full_enq_rdy", 64'(io_enq_rdy), 64'd0);
        check("head_addr", 64'(io_tx_addr), 64'h10);
        check("tx_enq_bp", 64'(io_tx_enq), 64'd1);
        push(1'b0, ADDR_W'(32'h14));
        check("refused_head", 64'(io_tx_addr), 64'h10);
        check("refused_sb", 64'(sb.size()), 64'd4);
        a0 = acc_cnt;
        io_tx_rdy = 1'b1;
        step();
        check("issue_1", 64'(acc_cnt - a0), 64'd1);
        io_tx_comp = 1'b1;  // accept+comp together from here on
        for (int k = 2; k <= 4; k++) begin
            step();
            check("issue_n", 64'(acc_cnt - a0), 64'(k));
            check("simul_out", 64'(io_outstanding), 64'd1);
        end
        io_tx_comp = 1'b0;
        check("simul_cnt", 64'(io_comp_cnt), 64'd3);
        check("simul_err", 64'(io_err), 64'd0);
        io_tx_rdy = 1'b0;
        io_tx_comp = 1'b1;
        step();
        io_tx_comp = 1'b0;
        check("t2_idle", 64'(io_idle), 64'd1);
        check("t2_cnt", 64'(io_comp_cnt), 64'd4);

        // Outstanding limit.
        for (int i = 0; i < 4; i++) push(1'b0, ADDR_W'(32'h20 + i));
        a0 = acc_cnt;
        io_tx_rdy = 1'b1;
        repeat (3) step();
        check("lim_acc", 64'(acc_cnt - a0), 64'd2);
        check("lim_tx_enq", 64'(io_tx_enq), 64'd0);
        check("lim_out", 64'(io_outstanding), 64'd2);
        for (int k = 3; k <= 4; k++) begin
            io_tx_comp = 1'b1;
            step();
            io_tx_comp = 1'b0;
            check("lim_release", 64'(io_tx_enq), 64'd1);
            step();
            check("lim_acc_n", 64'(acc_cnt - a0), 64'(k));
            check("lim_out_n", 64'(io_outstanding), 64'd2);
        end
        io_tx_comp = 1'b1;
        repeat (2) step();
        io_tx_comp = 1'b0;
        check("lim_cnt", 64'(io_comp_cnt), 64'd8);
        check("lim_idle", 64'(io_idle), 64'd1);

        // Drain with 1 in flight and 3 queued.
        io_tx_rdy = 1'b0;
        push(1'b1, ADDR_W'(32'h30));
        io_tx_rdy = 1'b1;
        step();
        io_tx_rdy = 1'b0;
        for (int i = 1; i < 4; i++) push(1'b1, ADDR_W'(32'h30 + i));
        check("drn_pre_out", 64'(io_outstanding), 64'd1);
        io_drain = 1'b1;
        step();
        io_drain = 1'b0;
        check("drn_enq_rdy", 64'(io_enq_rdy), 64'd0);
        io_tx_rdy = 1'b1;
        idle_cyc = -1; done_cyc = -1; done_n = 0;
        for (int c = 0; c < 30; c++) begin
            io_tx_comp = (io_outstanding != '0);
            step();
            if (io_idle && idle_cyc < 0) idle_cyc = c;
            if (io_done) begin
                done_n++;
                done_cyc = c;
                check("done_tx_enq", 64'(io_tx_enq), 64'd0);
            end
        end
        io_tx_comp = 1'b0;
        check("drn_done_n", 64'(done_n), 64'd1);
        check("drn_done_lat", 64'(done_cyc - idle_cyc), 64'd1);
        check("drn_cnt", 64'(io_comp_cnt), 64'd12);
        check("drn_back_run", 64'(io_enq_rdy), 64'd1);

        // Spurious completion, then counter wrap.
        io_tx_rdy = 1'b0;
        io_tx_comp = 1'b1;
        step();
        io_tx_comp = 1'b0;
        check("spur_err", 64'(io_err), 64'd1);
        check("spur_cnt", 64'(io_comp_cnt), 64'd12);
        check("spur_out", 64'(io_outstanding), 64'd0);
        step();
        check("spur_sticky", 64'(io_err), 64'd1);
        exp_cnt = 8'd12;
        for (int i = 0; i < 256; i++) begin
            push(i[0], ADDR_W'(32'h1000 + i));
            io_tx_rdy = 1'b1;
            step();
            io_tx_rdy = 1'b0;
            io_tx_comp = 1'b1;
            step();
            io_tx_comp = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd0) check("wrap_zero", 64'(io_comp_cnt), 64'd0);
        end
        check("wrap_end", 64'(io_comp_cnt), 64'(exp_cnt));
        check("wrap_err", 64'(io_err), 64'd1);

        // Reset mid-stream: 2 outstanding, 2 queued.
        io_tx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, ADDR_W'(32'h40 + i));
        io_tx_rdy = 1'b1;
        repeat (2) step();
        io_tx_rdy = 1'b0;
        check("mid_out", 64'(io_outstanding), 64'd2);
        reset = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_enq_rdy", 64'(io_enq_rdy), 64'd1);
        check("mid_rst_tx_enq", 64'(io_tx_enq), 64'd0);
        check("mid_rst_done", 64'(io_done), 64'd0);
        check("mid_rst_idle", 64'(io_idle), 64'd1);
        check("mid_rst_out", 64'(io_outstanding), 64'd0);
        check("mid_rst_cnt", 64'(io_comp_cnt), 64'd0);
        check("mid_rst_err", 64'(io_err), 64'd0);
        step();
        #3 reset = 1'b1;
        step();
        check("post_rst_out", 64'(io_outstanding), 64'd0);
        check("post_rst_idle", 64'(io_idle), 64'd1);
        check("post_rst_done", 64'(io_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
